// File: rtl/dispatch_pkg.sv
// Shared types and default constants for the go/done job dispatcher.
//   dispatch_state_t : dispatcher FSM state encoding (IDLE, ISSUE, WAIT)
//   DISPATCH_*       : default parameter values for the dispatcher and its FIFO
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } dispatch_state_t;

    localparam int DISPATCH_DEPTH   = 4;
    localparam int DISPATCH_ID_W    = 4;
    localparam int DISPATCH_TIMEOUT = 32;

endpackage

// File: rtl/go_dispatcher_if.sv
// Bundle of the dispatcher's request, downstream and completion signals.
//   req_valid/req_ready/req_id : job request handshake
//   go/done                    : start pulse to and completion from the counter
//   busy, pending              : dispatcher status
//   cmp_valid/cmp_id/cmp_timeout : completion report
// slave is the dispatcher side; master is the side driving requests and done.
interface go_dispatcher_if #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [ID_W-1:0]  req_id;
    logic             go;
    logic             done;
    logic             busy;
    logic             cmp_valid;
    logic [ID_W-1:0]  cmp_id;
    logic             cmp_timeout;
    logic [CNT_W-1:0] pending;

    modport master (
        output req_valid, req_id, done,
        input  req_ready, go, busy, cmp_valid, cmp_id, cmp_timeout, pending
    );

    modport slave (
        input  req_valid, req_id, done,
        output req_ready, go, busy, cmp_valid, cmp_id, cmp_timeout, pending
    );

endinterface

// File: rtl/go_req_fifo.sv
// Synchronous request FIFO holding job IDs, first-word-fall-through.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write din when push (accepted when not full, or full with pop)
//   pop        : drop the head entry (ignored when empty)
//   dout       : current head entry
//   count      : occupancy; full / empty flags
module go_req_fifo #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [ID_W-1:0]  din,
    output logic [ID_W-1:0]  dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A write while full is only safe when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
        else if (!wr_en && rd_en) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/go_dispatcher.sv
// Job dispatcher feeding the go/done counter. Buffers tagged requests,
// issues one go pulse per job, waits for done or a watchdog timeout and
// reports the result with the job ID. One job in flight at a time.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request handshake, go/done, busy, pending, completion report
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | nothing in flight; leave when the FIFO holds a job
//   ISSUE | one cycle: go high, pop head into active_id, clear timer
//   WAIT  | count cycles until done or TIMEOUT, then report
module go_dispatcher
    import dispatch_pkg::*;
#(
    parameter int DEPTH   = DISPATCH_DEPTH,
    parameter int ID_W    = DISPATCH_ID_W,
    parameter int TIMEOUT = DISPATCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    go_dispatcher_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int CNT_W = $clog2(DEPTH + 1);

    dispatch_state_t  state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic [ID_W-1:0]  active_id_q;
    logic             cmp_valid_q;
    logic [ID_W-1:0]  cmp_id_q;
    logic             cmp_timeout_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]  fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             timer_last;
    logic             go_o, busy_o;

    // Ready comes purely from registered occupancy, so a pop cannot make
    // room for a push in the same cycle.
    assign fifo_push = bus.req_valid && !fifo_full;

    go_req_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.req_id),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign timer_last = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.done || timer_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        go_o     = 1'b0;
        busy_o   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ISSUE: begin
                go_o     = 1'b1;
                busy_o   = 1'b1;
                fifo_pop = 1'b1;
            end
            WAIT:    busy_o = 1'b1;
            default: ;
        endcase
    end

    // Timer, active job and completion report. done wins over a timeout
    // landing on the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q       <= '0;
            active_id_q   <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_id_q      <= '0;
            cmp_timeout_q <= 1'b0;
        end else begin
            cmp_valid_q <= 1'b0;
            case (state_q)
                ISSUE: begin
                    timer_q     <= '0;
                    active_id_q <= fifo_dout;
                end
                WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (bus.done) begin
                        cmp_valid_q   <= 1'b1;
                        cmp_id_q      <= active_id_q;
                        cmp_timeout_q <= 1'b0;
                    end else if (timer_last) begin
                        cmp_valid_q   <= 1'b1;
                        cmp_id_q      <= active_id_q;
                        cmp_timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.go          = go_o;
    assign bus.busy        = busy_o;
    assign bus.pending     = fifo_count;
    assign bus.cmp_valid   = cmp_valid_q;
    assign bus.cmp_id      = cmp_id_q;
    assign bus.cmp_timeout = cmp_timeout_q;

endmodule
